brq_bus_arbiter: RTL

//  Shares a single req/gnt/rvalid memory port between the brq_core instruction-fetch and data (LSU) requesters.

---
 rtl/brq_bus_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/brq_bus_arbiter.sv
// Two-requester (instr fetch / LSU) arbiter onto one req/gnt/rvalid port.
// An in-order owner FIFO steers each response back to the requester that issued it.
module brq_bus_arbiter #(
    parameter int   MAX_OUTSTANDING = 2,
    parameter logic FIXED_PRIO      = 1'b0,
    localparam int  CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          instr_req_i,
    output logic          instr_gnt_o,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,
    input  logic          data_req_i,
    output logic          data_gnt_o,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic          data_rvalid_o,
    output logic [31:0]   data_rdata_o,
    output logic          data_err_o,
    output logic          m_req_o,
    input  logic          m_gnt_i,
    output logic          m_we_o,
    output logic [3:0]    m_be_o,
    output logic [31:0]   m_addr_o,
    output logic [31:0]   m_wdata_o,
    input  logic          m_rvalid_i,
    input  logic [31:0]   m_rdata_i,
    input  logic          m_err_i,
    output logic [CW-1:0] outstanding_o,
    output logic          proto_err_o
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    // Owner encoding everywhere: 0 = instr, 1 = data.
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       lock_q, lock_d, lock_data_q, lock_data_d;
    logic                       rr_last_q, rr_last_d;
    logic                       proto_err_q, proto_err_d;

    logic full, empty, win_data, win_req, push, pop, head_data;

    assign full      = (count_q == CW'(MAX_OUTSTANDING));
    assign empty     = (count_q == '0);
    assign head_data = fifo_q[rd_ptr_q];

    always_comb begin
        win_data = data_req_i;
        if (lock_q)
            win_data = lock_data_q;
        else if (instr_req_i && data_req_i)
            win_data = FIXED_PRIO ? 1'b1 : !rr_last_q;
    end

    assign win_req = win_data ? data_req_i : instr_req_i;
    assign m_req_o = reset && !full && win_req;
    assign push    = m_req_o && m_gnt_i;
    assign pop     = m_rvalid_i && !empty;

    assign m_we_o    = win_data && data_we_i;
    assign m_be_o    = win_data ? data_be_i : 4'hF;
    assign m_addr_o  = win_data ? data_addr_i : instr_addr_i;
    assign m_wdata_o = win_data ? data_wdata_i : 32'h0;

    assign instr_gnt_o    = push && !win_data;
    assign data_gnt_o     = push && win_data;
    assign instr_rvalid_o = reset && pop && !head_data;
    assign data_rvalid_o  = reset && pop && head_data;
    assign instr_rdata_o  = m_rdata_i;
    assign data_rdata_o   = m_rdata_i;
    assign instr_err_o    = m_err_i;
    assign data_err_o     = m_err_i;
    assign outstanding_o  = count_q;
    assign proto_err_o    = proto_err_q;

    always_comb begin
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rr_last_d   = rr_last_q;
        // A stalled request keeps its owner latched so the other side cannot steal the port.
        lock_d      = m_req_o && !m_gnt_i;
        lock_data_d = lock_d ? win_data : lock_data_q;
        proto_err_d = proto_err_q || (m_rvalid_i && empty);
        if (push) begin
            fifo_d[wr_ptr_q] = win_data;
            wr_ptr_d  = (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PW'(1);
            rr_last_d = win_data;
        end
        if (pop)
            rd_ptr_d = (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fifo_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lock_q      <= 1'b0;
            lock_data_q <= 1'b0;
            rr_last_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lock_q      <= lock_d;
            lock_data_q <= lock_data_d;
            rr_last_q   <= rr_last_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule
